alu_issue: RTL and testbench



---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_issue_regfile.sv | 38 +++
 rtl/alu_issue.sv | 133 +++++++++++++
 tb/tb_alu_issue.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, opcode values, instruction field layout
// and the legal-opcode check used by the issue stage and the ALU.
package alu_pkg;

  localparam int XLEN    = 24;
  localparam int INSTR_W = 24;

  localparam int OP_MSB  = 23;
  localparam int OP_LSB  = 20;
  localparam int RD_MSB  = 19;
  localparam int RD_LSB  = 16;
  localparam int RS1_MSB = 15;
  localparam int RS1_LSB = 12;
  localparam int RS2_MSB = 11;
  localparam int RS2_LSB = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_ADDI = 4'b1100;
  localparam logic [3:0] OP_MULI = 4'b1101;

  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_XOR, OP_NOT,
      OP_AND, OP_OR, OP_ADDI, OP_MULI: legal = 1'b1;
      default:                         legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Register file for the ALU issue stage: two operand read ports, one write port
// and a debug read port. Register 0 always reads zero and never stores data.
module alu_regfile #(
  parameter int XLEN = 24,
  parameter int NREG = 16,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra1,
  output logic [XLEN-1:0] rd1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] mem_r [NREG];

  // Storage array; entry 0 is held at zero so the read muxes are the only special case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= {XLEN{1'b0}};
      end
    end else if (we && (wa != {AW{1'b0}})) begin
      mem_r[wa] <= wd;
    end
  end

  assign rd1      = (ra1 == {AW{1'b0}})      ? {XLEN{1'b0}} : mem_r[ra1];
  assign rd2      = (ra2 == {AW{1'b0}})      ? {XLEN{1'b0}} : mem_r[ra2];
  assign dbg_data = (dbg_addr == {AW{1'b0}}) ? {XLEN{1'b0}} : mem_r[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Operand-issue stage feeding the 24-bit ALU: decodes, reads/forwards operands
// into the execute register and writes the ALU result back as it retires.
module alu_issue #(
  parameter int XLEN  = alu_pkg::XLEN,
  parameter int NREG  = 16,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        instr_valid,
  input  logic [alu_pkg::INSTR_W-1:0] instr,
  output logic                        instr_ready,
  input  logic                        ex_stall,
  output logic [XLEN-1:0]             in1,
  output logic [XLEN-1:0]             in2,
  output logic [7:0]                  absVal,
  output logic [3:0]                  alu_control,
  output logic                        ex_valid,
  input  logic [XLEN-1:0]             alu_result,
  output logic                        illegal,
  output logic [CNT_W-1:0]            retired,
  input  logic [3:0]                  dbg_addr,
  output logic [XLEN-1:0]             dbg_data
);
  import alu_pkg::*;

  logic [3:0]       op_s;
  logic [3:0]       rd_s;
  logic [3:0]       rs1_s;
  logic [3:0]       rs2_s;
  logic [7:0]       imm_s;
  logic             handshake_s;
  logic             legal_s;
  logic             wb_en_s;
  logic             rf_we_s;
  logic [XLEN-1:0]  rf_rd1_s;
  logic [XLEN-1:0]  rf_rd2_s;
  logic [XLEN-1:0]  opa_s;
  logic [XLEN-1:0]  opb_s;

  logic [XLEN-1:0]  in1_r;
  logic [XLEN-1:0]  in2_r;
  logic [7:0]       imm_r;
  logic [3:0]       op_r;
  logic [3:0]       ex_rd_r;
  logic             ex_valid_r;
  logic             illegal_r;
  logic [CNT_W-1:0] retired_r;

  assign op_s  = instr[OP_MSB:OP_LSB];
  assign rd_s  = instr[RD_MSB:RD_LSB];
  assign rs1_s = instr[RS1_MSB:RS1_LSB];
  assign rs2_s = instr[RS2_MSB:RS2_LSB];
  assign imm_s = instr[IMM_MSB:IMM_LSB];

  assign instr_ready = rst_n && !ex_stall;

  // Decode, and bypass the retiring result so a dependent instruction never sees a stale register.
  always_comb begin
    handshake_s = instr_valid && instr_ready;
    legal_s     = is_legal_op(op_s);
    wb_en_s     = ex_valid_r && !ex_stall;
    rf_we_s     = wb_en_s && (ex_rd_r != 4'd0);
    if (ex_valid_r && (rs1_s == ex_rd_r) && (rs1_s != 4'd0)) begin
      opa_s = alu_result;
    end else begin
      opa_s = rf_rd1_s;
    end
    if (ex_valid_r && (rs2_s == ex_rd_r) && (rs2_s != 4'd0)) begin
      opb_s = alu_result;
    end else begin
      opb_s = rf_rd2_s;
    end
  end

  // Execute register, illegal pulse and retire counter; a stall freezes the execute contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in1_r      <= {XLEN{1'b0}};
      in2_r      <= {XLEN{1'b0}};
      imm_r      <= 8'd0;
      op_r       <= 4'd0;
      ex_rd_r    <= 4'd0;
      ex_valid_r <= 1'b0;
      illegal_r  <= 1'b0;
      retired_r  <= {CNT_W{1'b0}};
    end else begin
      illegal_r <= handshake_s && !legal_s;
      if (wb_en_s) begin
        retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (!ex_stall) begin
        if (handshake_s && legal_s) begin
          in1_r      <= opa_s;
          in2_r      <= opb_s;
          imm_r      <= imm_s;
          op_r       <= op_s;
          ex_rd_r    <= rd_s;
          ex_valid_r <= 1'b1;
        end else begin
          ex_valid_r <= 1'b0;
        end
      end
    end
  end

  alu_regfile #(
    .XLEN (XLEN),
    .NREG (NREG),
    .AW   (4)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra1      (rs1_s),
    .rd1      (rf_rd1_s),
    .ra2      (rs2_s),
    .rd2      (rf_rd2_s),
    .we       (rf_we_s),
    .wa       (ex_rd_r),
    .wd       (alu_result),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign in1         = in1_r;
  assign in2         = in2_r;
  assign absVal      = imm_r;
  assign alu_control = op_r;
  assign ex_valid    = ex_valid_r;
  assign illegal     = illegal_r;
  assign retired     = retired_r;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios plus randomized traffic checked against
// a sequential instruction-set model of the register file.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [23:0] instr = 24'd0;
  logic        instr_ready;
  logic        ex_stall = 1'b0;
  logic [23:0] in1, in2;
  logic [7:0]  absVal;
  logic [3:0]  alu_control;
  logic        ex_valid;
  logic [23:0] alu_result;
  logic        illegal;
  logic [15:0] retired;
  logic [3:0]  dbg_addr = 4'd0;
  logic [23:0] dbg_data;

  int total = 0;
  int bad = 0;

  logic [23:0] mreg [16];
  int unsigned mret;
  logic [23:0] exp_in1, exp_in2;
  logic [7:0]  exp_imm;
  logic [3:0]  exp_op;
  logic        exp_valid, exp_legal;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .ex_stall(ex_stall), .in1(in1), .in2(in2),
    .absVal(absVal), .alu_control(alu_control), .ex_valid(ex_valid),
    .alu_result(alu_result), .illegal(illegal), .retired(retired),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  function automatic logic [23:0] alu_fn(input logic [3:0] op, input logic [23:0] a,
                                         input logic [23:0] b, input logic [7:0] imm);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a * b;
      4'h3: return a ^ b;
      4'h4: return ~a;
      4'h5: return a & b;
      4'h6: return a | b;
      4'hC: return a + {16'd0, imm};
      4'hD: return a * {16'd0, imm};
      default: return 24'd0;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_control, in1, in2, absVal);

  function automatic logic [23:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [7:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 16; r++) mreg[r] = 24'd0;
    mret = 0;
    exp_in1 = 24'd0; exp_in2 = 24'd0; exp_imm = 8'd0; exp_op = 4'd0;
    exp_valid = 1'b0; exp_legal = 1'b1;
  endtask

  // Instructions take effect in program order; forwarding makes the pipeline look sequential.
  task automatic model_apply(input logic [23:0] ins);
    logic [3:0] op, rd, rs1, rs2;
    op = ins[23:20]; rd = ins[19:16]; rs1 = ins[15:12]; rs2 = ins[11:8];
    exp_legal = op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hC, 4'hD};
    exp_valid = exp_legal;
    if (exp_legal) begin
      exp_in1 = mreg[rs1];
      exp_in2 = mreg[rs2];
      exp_imm = ins[7:0];
      exp_op  = op;
      if (rd != 4'd0) mreg[rd] = alu_fn(op, exp_in1, exp_in2, ins[7:0]);
      mret = (mret + 1) % 65536;
    end
  endtask

  task automatic issue(input logic [23:0] ins);
    model_apply(ins);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      exp_valid = 1'b0;
    end
  endtask

  task automatic peek(input logic [3:0] a, output logic [23:0] v);
    dbg_addr = a;
    @(negedge clk);
    v = dbg_data;
  endtask

  task automatic test_reset();
    logic [23:0] v;
    model_reset();
    #3;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%0h exp=0", ex_valid); end
    total++; if ({in1, in2} !== 48'd0) begin bad++; $display("FAIL reset_operands got=%0h/%0h exp=0", in1, in2); end
    total++; if ({absVal, alu_control} !== 12'd0) begin bad++; $display("FAIL reset_imm_op got=%0h/%0h exp=0", absVal, alu_control); end
    total++; if ({illegal, instr_ready} !== 2'b00) begin bad++; $display("FAIL reset_illegal_ready got=%0b%0b exp=00", illegal, instr_ready); end
    total++; if (retired !== 16'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    @(negedge clk) rst_n = 1'b1;
    peek(4'd7, v);
    total++; if (v !== 24'd0) begin bad++; $display("FAIL reset_reg7 got=%0h exp=0", v); end
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%0b exp=1", instr_ready); end
  endtask

  task automatic test_add();
    logic [23:0] v;
    issue(enc(4'hC, 4'd1, 4'd0, 4'd0, 8'd8));
    issue(enc(4'hC, 4'd2, 4'd0, 4'd0, 8'd4));
    issue(enc(4'h0, 4'd3, 4'd1, 4'd2, 8'd0));
    total++; if (in1 !== 24'd8) begin bad++; $display("FAIL add_in1 got=%0d exp=8", in1); end
    total++; if (in2 !== 24'd4) begin bad++; $display("FAIL add_in2 got=%0d exp=4", in2); end
    total++; if (alu_control !== 4'h0) begin bad++; $display("FAIL add_ctrl got=%0h exp=0", alu_control); end
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL add_ex_valid got=%0b exp=1", ex_valid); end
    idle(1);
    peek(4'd3, v);
    total++; if (v !== 24'd12) begin bad++; $display("FAIL add_r3 got=%0d exp=12", v); end
    total++; if (retired !== 16'd3) begin bad++; $display("FAIL add_retired got=%0d exp=3", retired); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] v;
    issue(enc(4'hC, 4'd1, 4'd0, 4'd0, 8'd5));
    issue(enc(4'hD, 4'd4, 4'd1, 4'd0, 8'd3));
    total++; if (in1 !== 24'd5) begin bad++; $display("FAIL fwd_in1 got=%0d exp=5", in1); end
    total++; if (absVal !== 8'd3) begin bad++; $display("FAIL fwd_imm got=%0d exp=3", absVal); end
    total++; if (alu_control !== 4'hD) begin bad++; $display("FAIL fwd_ctrl got=%0h exp=d", alu_control); end
    idle(1);
    peek(4'd4, v);
    total++; if (v !== 24'd15) begin bad++; $display("FAIL fwd_r4 got=%0d exp=15", v); end
    total++; if (retired !== 16'(mret)) begin bad++; $display("FAIL fwd_retired got=%0d exp=%0d", retired, mret); end
  endtask

  task automatic test_illegal();
    logic [23:0] v;
    issue(enc(4'hA, 4'd6, 4'd1, 4'd1, 8'h11));
    total++; if (illegal !== 1'b1) begin bad++; $display("FAIL ill_pulse got=%0b exp=1", illegal); end
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL ill_ex_valid got=%0b exp=0", ex_valid); end
    total++; if (in1 !== exp_in1) begin bad++; $display("FAIL ill_in1_hold got=%0d exp=%0d", in1, exp_in1); end
    idle(1);
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL ill_pulse_end got=%0b exp=0", illegal); end
    total++; if (retired !== 16'(mret)) begin bad++; $display("FAIL ill_retired got=%0d exp=%0d", retired, mret); end
    peek(4'd6, v);
    total++; if (v !== mreg[6]) begin bad++; $display("FAIL ill_r6 got=%0h exp=%0h", v, mreg[6]); end
  endtask

  task automatic test_stall();
    logic [23:0] v;
    logic [15:0] rb;
    issue(enc(4'hC, 4'd7, 4'd0, 4'd0, 8'hFF));
    issue(enc(4'hC, 4'd8, 4'd0, 4'd0, 8'd1));
    issue(enc(4'h3, 4'd5, 4'd7, 4'd8, 8'd0));
    total++; if ({in1, in2} !== {24'd255, 24'd1}) begin bad++; $display("FAIL xor_operands got=%0d/%0d exp=255/1", in1, in2); end
    rb = 16'(mret - 1);
    ex_stall = 1'b1;
    instr_valid = 1'b1;
    instr = enc(4'h0, 4'd9, 4'd1, 4'd1, 8'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL stall_ready c=%0d got=%0b exp=0", c, instr_ready); end
      total++; if ({ex_valid, alu_control, in1, in2} !== {1'b1, 4'h3, 24'd255, 24'd1}) begin
        bad++; $display("FAIL stall_hold c=%0d got=%0b/%0h/%0d/%0d exp=1/3/255/1", c, ex_valid, alu_control, in1, in2); end
      total++; if (retired !== rb) begin bad++; $display("FAIL stall_retired c=%0d got=%0d exp=%0d", c, retired, rb); end
      peek(4'd5, v);
      total++; if (v !== 24'd0) begin bad++; $display("FAIL stall_r5_early c=%0d got=%0d exp=0", c, v); end
    end
    instr_valid = 1'b0;
    ex_stall = 1'b0;
    @(posedge clk); #1;
    exp_valid = 1'b0;
    total++; if (retired !== 16'(mret)) begin bad++; $display("FAIL stall_release_retired got=%0d exp=%0d", retired, mret); end
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL stall_release_valid got=%0b exp=0", ex_valid); end
    peek(4'd5, v);
    total++; if (v !== 24'd254) begin bad++; $display("FAIL stall_r5 got=%0d exp=254", v); end
    idle(2);
    total++; if (retired !== 16'(mret)) begin bad++; $display("FAIL stall_once got=%0d exp=%0d", retired, mret); end
  endtask

  task automatic test_r0();
    logic [23:0] v;
    issue(enc(4'hC, 4'd0, 4'd0, 4'd0, 8'd9));
    issue(enc(4'h0, 4'd9, 4'd0, 4'd1, 8'd0));
    total++; if (in1 !== 24'd0) begin bad++; $display("FAIL r0_no_fwd got=%0d exp=0", in1); end
    total++; if (in2 !== mreg[1]) begin bad++; $display("FAIL r0_in2 got=%0d exp=%0d", in2, mreg[1]); end
    idle(1);
    peek(4'd0, v);
    total++; if (v !== 24'd0) begin bad++; $display("FAIL r0_dbg got=%0d exp=0", v); end
    peek(4'd9, v);
    total++; if (v !== mreg[9]) begin bad++; $display("FAIL r0_r9 got=%0d exp=%0d", v, mreg[9]); end
  endtask

  task automatic test_random();
    logic [3:0] ops [9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hC, 4'hD};
    logic [3:0] op;
    logic [23:0] v;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        ex_stall = 1'b1;
        instr_valid = 1'($urandom_range(0, 1));
        instr = 24'($urandom);
        @(posedge clk); #1;
        total++; if ({ex_valid, in1, in2, absVal, alu_control} !== {exp_valid, exp_in1, exp_in2, exp_imm, exp_op}) begin
          bad++; $display("FAIL rnd_stall_hold it=%0d got=%0b/%0h/%0h/%0h/%0h exp=%0b/%0h/%0h/%0h/%0h", it,
            ex_valid, in1, in2, absVal, alu_control, exp_valid, exp_in1, exp_in2, exp_imm, exp_op); end
        total++; if ({instr_ready, illegal} !== 2'b00) begin bad++; $display("FAIL rnd_stall_ready it=%0d got=%0b%0b exp=00", it, instr_ready, illegal); end
        ex_stall = 1'b0;
        instr_valid = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        idle(1);
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rnd_bubble it=%0d got=%0b exp=0", it, ex_valid); end
      end else begin
        op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ops[$urandom_range(0, 8)];
        issue(enc(op, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 8'($urandom)));
        total++; if ({ex_valid, illegal} !== {exp_valid, !exp_legal}) begin
          bad++; $display("FAIL rnd_valid it=%0d op=%0h got=%0b%0b exp=%0b%0b", it, op, ex_valid, illegal, exp_valid, !exp_legal); end
        total++; if ({in1, in2, absVal, alu_control} !== {exp_in1, exp_in2, exp_imm, exp_op}) begin
          bad++; $display("FAIL rnd_operands it=%0d got=%0h/%0h/%0h/%0h exp=%0h/%0h/%0h/%0h", it,
            in1, in2, absVal, alu_control, exp_in1, exp_in2, exp_imm, exp_op); end
        total++; if (retired !== 16'(mret - 32'(exp_valid))) begin
          bad++; $display("FAIL rnd_retired it=%0d got=%0d exp=%0d", it, retired, 16'(mret - 32'(exp_valid))); end
      end
    end
    idle(1);
    for (int r = 0; r < 16; r++) begin
      peek(4'(r), v);
      total++; if (v !== mreg[r]) begin bad++; $display("FAIL rnd_reg r%0d got=%0h exp=%0h", r, v, mreg[r]); end
    end
    total++; if (retired !== 16'(mret)) begin bad++; $display("FAIL rnd_final_retired got=%0d exp=%0d", retired, mret); end
  endtask

  task automatic test_reset_mid();
    logic [23:0] v;
    issue(enc(4'hC, 4'd1, 4'd0, 4'd0, 8'd77));
    issue(enc(4'h0, 4'd10, 4'd1, 4'd1, 8'h55));
    total++; if ({ex_valid, in1} !== {1'b1, 24'd77}) begin bad++; $display("FAIL mid_setup got=%0b/%0d exp=1/77", ex_valid, in1); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({ex_valid, illegal, instr_ready} !== 3'b000) begin bad++; $display("FAIL mid_flags got=%0b%0b%0b exp=000", ex_valid, illegal, instr_ready); end
    total++; if ({in1, in2, absVal, alu_control} !== 60'd0) begin bad++; $display("FAIL mid_operands got=%0h/%0h/%0h/%0h exp=0", in1, in2, absVal, alu_control); end
    total++; if (retired !== 16'd0) begin bad++; $display("FAIL mid_retired got=%0d exp=0", retired); end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    idle(1);
    for (int r = 0; r < 16; r++) begin
      peek(4'(r), v);
      total++; if (v !== 24'd0) begin bad++; $display("FAIL mid_reg r%0d got=%0h exp=0", r, v); end
    end
    total++; if (retired !== 16'd0) begin bad++; $display("FAIL mid_retired_after got=%0d exp=0", retired); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_illegal();
    test_stall();
    test_r0();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
